exception_tracker: RTL and testbench
====================================

Name: exception_tracker

Overview:
Registered, parameterised successor to the combinational exception detector. It collects exception candidates from IF, ID and MEM, selects the oldest in program order (MEM > ID > IF), and latches cause, pc and tval. It then holds them to the trap/CSR unit through a valid/ready handshake, runs a fixed-length pipeline flush, and tracks trap nesting to flag double faults.

Parameters:
XLEN, 32, datapath width (32 or 64)
C_EXT, 1, 1: IF misaligned when pc[0]=1; 0: when pc[1:0]!=0
MISALIGN_TRAP, 0, 1: raise load/store misaligned causes; 0: misaligned data access never traps
FLUSH_CYCLES, 2, cycles flush is held after handshake (1..15)
MAX_NEST, 2, trap nesting depth before double_fault (1..7)

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
current_priv  in  2  privilege mode (00 U, 01 S, 11 M)
if_valid, if_page_fault  in  1 each  IF qualifiers
if_pc, if_fault_vaddr  in  XLEN each  IF pc / faulting VA
id_valid, id_illegal_inst, id_ecall, id_ebreak, id_mret, id_sret  in  1 each  ID decode flags
id_pc  in  XLEN  ID pc
id_instruction  in  32  ID instruction word
mem_valid, mem_read, mem_write, mem_page_fault  in  1 each  MEM qualifiers
mem_funct3  in  3  load/store size
mem_addr, mem_pc, mem_fault_vaddr  in  XLEN each  MEM address / pc / faulting VA
exc_cancel  in  1  drop held exception (interrupt or external redirect wins)
trap_ready  in  1  trap unit accepts exception
trap_done  in  1  xRET retired; decrements nesting
exc_detect  out  1  combinational: candidate present while IDLE
exc_valid  out  1  registered exception held
exc_code  out  5  cause
exc_pc  out  XLEN  faulting pc
exc_tval  out  XLEN  trap value
pipe_hold  out  1  state != IDLE
flush  out  1  asserted in FLUSH
nest_depth  out  3  current trap depth
double_fault  out  1  sticky fault flag

Behaviour:
- Reset values: all outputs 0; state IDLE; flush counter 0.
- Candidate selection (combinational):
  - MEM: store page fault (mem_write), then load page fault (mem_read && !mem_write). If MISALIGN_TRAP: load misaligned, then store misaligned. Misaligned means H: addr[0]; W: addr[1:0]!=0; D: addr[2:0]!=0. tval = fault vaddr or mem_addr.
  - ID: illegal, then EBREAK, then ECALL.
    - Illegal = id_illegal_inst, or MRET with priv!=11, or SRET with priv==00; tval = zero-extended id_instruction.
    - EBREAK tval = id_pc.
    - ECALL cause = 8/9/11 by priv; tval = 0.
  - IF: misaligned (cause 0, tval = if_pc), then page fault (cause 12, tval = if_fault_vaddr).
  - Every candidate is gated by its stage valid.
- FSM:
  - IDLE: on a candidate (and !exc_cancel), latch code/pc/tval and go to PENDING. exc_valid rises the next cycle (1-cycle latency).
  - PENDING: code/pc/tval are stable and inputs are ignored.
    - exc_cancel=1 → IDLE with exc_valid=0; cancel wins over a same-cycle trap_ready.
    - trap_ready=1 → FLUSH; counter loaded with FLUSH_CYCLES; nesting updated.
  - FLUSH: flush=1 for exactly FLUSH_CYCLES cycles; exc_valid=0; candidates ignored. Then IDLE.
- Nesting:
  - Handshake: depth+1, saturating at MAX_NEST.
  - Handshake while depth==MAX_NEST: double_fault=1, sticky until reset.
  - trap_done: depth-1, floor 0.
  - Same cycle handshake and trap_done: depth unchanged; double_fault still evaluated against the pre-update depth.
- exc_detect is purely combinational and valid only in IDLE, so the pipeline can squash in the same cycle.
- Asynchronous reset mid-PENDING/FLUSH returns to IDLE immediately with all outputs 0.
- RV32: funct3 011 never counts as misaligned.

Test Plan:
- Same cycle: IF misaligned pc=0x102 (C_EXT=0) and MEM load page fault va=0x8000_0004 → next cycle exc_valid=1, code=13, tval=0x8000_0004.
- ECALL at priv=01, id_pc=0x200; trap_ready on 3rd PENDING cycle → code=9 held 3 cycles, then flush=1 for 2 cycles, nest_depth=1.
- MRET at priv=00, instr=0x30200073 → code=2, tval=0x30200073.
- MISALIGN_TRAP=1, SW addr=0x1002 → code=6, tval=0x1002; MISALIGN_TRAP=0 with same stimulus → no exception.
- MAX_NEST=2: three handshakes with no trap_done → double_fault=1 after the third and stays 1; reset_n low clears it.
- PENDING with exc_cancel and trap_ready in the same cycle → IDLE, no flush; reset_n low during FLUSH → flush=0 immediately.

Source files
------------

// File: rtl/exception_tracker.sv
// Registered exception tracker: picks the oldest faulting stage (MEM > ID > IF), holds
// cause/pc/tval for the trap unit, runs a fixed-length flush and tracks trap nesting.
module exception_tracker #(
  parameter int XLEN          = 32,
  parameter int C_EXT         = 1,
  parameter int MISALIGN_TRAP = 0,
  parameter int FLUSH_CYCLES  = 2,
  parameter int MAX_NEST      = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      current_priv,
  input  logic            if_valid,
  input  logic            if_page_fault,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_fault_vaddr,
  input  logic            id_valid,
  input  logic            id_illegal_inst,
  input  logic            id_ecall,
  input  logic            id_ebreak,
  input  logic            id_mret,
  input  logic            id_sret,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_instruction,
  input  logic            mem_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_page_fault,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_pc,
  input  logic [XLEN-1:0] mem_fault_vaddr,
  input  logic            exc_cancel,
  input  logic            trap_ready,
  input  logic            trap_done,
  output logic            exc_detect,
  output logic            exc_valid,
  output logic [4:0]      exc_code,
  output logic [XLEN-1:0] exc_pc,
  output logic [XLEN-1:0] exc_tval,
  output logic            pipe_hold,
  output logic            flush,
  output logic [2:0]      nest_depth,
  output logic            double_fault
);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_FLUSH} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [2:0] NEST_MAX   = 3'(MAX_NEST);

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic [2:0]        r_depth;
  logic              r_df;
  logic [4:0]        r_code;
  logic [XLEN-1:0]   r_pc, r_tval;

  logic              w_cand, w_ld, w_mis_data, w_if_mis, w_illegal, w_hs, w_capture;
  logic [4:0]        w_code;
  logic [XLEN-1:0]   w_pc, w_tval;
  logic              w_unused;

  assign w_unused  = mem_funct3[2];
  assign w_ld      = mem_read && !mem_write;
  assign w_if_mis  = (C_EXT != 0) ? if_pc[0] : (if_pc[1:0] != 2'b00);
  assign w_illegal = id_illegal_inst || (id_mret && current_priv != 2'b11) ||
                     (id_sret && current_priv == 2'b00);

  // Doubleword accesses only exist on RV64, so funct3=011 never misaligns on RV32.
  always_comb begin
    w_mis_data = 1'b0;
    case (mem_funct3[1:0])
      2'b01:   w_mis_data = mem_addr[0];
      2'b10:   w_mis_data = (mem_addr[1:0] != 2'b00);
      2'b11:   w_mis_data = (XLEN == 64) && (mem_addr[2:0] != 3'b000);
      default: w_mis_data = 1'b0;
    endcase
  end

  always_comb begin
    w_cand = 1'b1;
    w_code = '0;
    w_pc   = '0;
    w_tval = '0;
    if (mem_valid && mem_write && mem_page_fault) begin
      w_code = 5'd15; w_pc = mem_pc; w_tval = mem_fault_vaddr;
    end else if (mem_valid && w_ld && mem_page_fault) begin
      w_code = 5'd13; w_pc = mem_pc; w_tval = mem_fault_vaddr;
    end else if (MISALIGN_TRAP != 0 && mem_valid && w_ld && w_mis_data) begin
      w_code = 5'd4; w_pc = mem_pc; w_tval = mem_addr;
    end else if (MISALIGN_TRAP != 0 && mem_valid && mem_write && w_mis_data) begin
      w_code = 5'd6; w_pc = mem_pc; w_tval = mem_addr;
    end else if (id_valid && w_illegal) begin
      w_code = 5'd2; w_pc = id_pc; w_tval = XLEN'(id_instruction);
    end else if (id_valid && id_ebreak) begin
      w_code = 5'd3; w_pc = id_pc; w_tval = id_pc;
    end else if (id_valid && id_ecall) begin
      w_code = 5'd8 + {3'b000, current_priv}; w_pc = id_pc;
    end else if (if_valid && w_if_mis) begin
      w_code = 5'd0; w_pc = if_pc; w_tval = if_pc;
    end else if (if_valid && if_page_fault) begin
      w_code = 5'd12; w_pc = if_pc; w_tval = if_fault_vaddr;
    end else begin
      w_cand = 1'b0;
    end
  end

  assign w_capture = (r_state == S_IDLE) && w_cand && !exc_cancel;
  assign w_hs      = (r_state == S_PENDING) && trap_ready && !exc_cancel;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_cand && !exc_cancel) w_next = S_PENDING;
      S_PENDING: begin
        if (exc_cancel)      w_next = S_IDLE;
        else if (trap_ready) w_next = S_FLUSH;
      end
      S_FLUSH:   if (r_cnt <= 4'd1) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_code  <= '0;
      r_pc    <= '0;
      r_tval  <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_code <= w_code;
        r_pc   <= w_pc;
        r_tval <= w_tval;
      end
      if (w_hs)                                   r_cnt <= FLUSH_LOAD;
      else if (r_state == S_FLUSH && r_cnt != '0) r_cnt <= r_cnt - 4'd1;
    end
  end

  // Simultaneous handshake and xRET cancel out; the fault check uses the pre-update depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_depth <= '0;
      r_df    <= 1'b0;
    end else begin
      if (w_hs && !trap_done) begin
        if (r_depth != NEST_MAX) r_depth <= r_depth + 3'd1;
      end else if (trap_done && !w_hs && r_depth != '0) begin
        r_depth <= r_depth - 3'd1;
      end
      if (w_hs && r_depth == NEST_MAX) r_df <= 1'b1;
    end
  end

  assign exc_detect   = (r_state == S_IDLE) && w_cand;
  assign exc_valid    = (r_state == S_PENDING);
  assign pipe_hold    = (r_state != S_IDLE);
  assign flush        = (r_state == S_FLUSH);
  assign exc_code     = r_code;
  assign exc_pc       = r_pc;
  assign exc_tval     = r_tval;
  assign nest_depth   = r_depth;
  assign double_fault = r_df;

endmodule

// File: tb/tb_exception_tracker.sv
// Scoreboard bench for exception_tracker: randomized stage faults vs a rule-level model.
module tb_exception_tracker;
  localparam int FC = 2;
  localparam int MN = 2;

  typedef struct {
    logic [1:0]  priv;
    logic        if_valid, if_pf;
    logic [31:0] if_pc, if_fva;
    logic        id_valid, ill, ecall, ebreak, mret, sret;
    logic [31:0] id_pc, instr;
    logic        mem_valid, rd, wr, mpf;
    logic [2:0]  f3;
    logic [31:0] maddr, mpc, mfva;
  } stim_t;
  typedef struct { logic [4:0] code; logic [31:0] pc, tval; int len; } exp_t;
  typedef struct { int depth; bit df; } fexp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]  current_priv;
  logic        if_valid, if_page_fault, id_valid, id_illegal_inst, id_ecall, id_ebreak;
  logic        id_mret, id_sret, mem_valid, mem_read, mem_write, mem_page_fault;
  logic [31:0] if_pc, if_fault_vaddr, id_pc, id_instruction, mem_addr, mem_pc, mem_fault_vaddr;
  logic [2:0]  mem_funct3;
  logic        exc_cancel, trap_ready, trap_done;
  logic        exc_detect, exc_valid, pipe_hold, flush, double_fault;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_tval;
  logic [2:0]  nest_depth;
  logic        b_detect, b_valid, b_hold, b_flush, b_df;
  logic [4:0]  b_code;
  logic [31:0] b_pc, b_tval;
  logic [2:0]  b_depth;

  exception_tracker #(.XLEN(32), .C_EXT(0), .MISALIGN_TRAP(1), .FLUSH_CYCLES(FC), .MAX_NEST(MN)) u_dut (
    .clk(clk), .reset_n(reset_n), .current_priv(current_priv),
    .if_valid(if_valid), .if_page_fault(if_page_fault), .if_pc(if_pc), .if_fault_vaddr(if_fault_vaddr),
    .id_valid(id_valid), .id_illegal_inst(id_illegal_inst), .id_ecall(id_ecall), .id_ebreak(id_ebreak),
    .id_mret(id_mret), .id_sret(id_sret), .id_pc(id_pc), .id_instruction(id_instruction),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write), .mem_page_fault(mem_page_fault),
    .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_pc(mem_pc), .mem_fault_vaddr(mem_fault_vaddr),
    .exc_cancel(exc_cancel), .trap_ready(trap_ready), .trap_done(trap_done),
    .exc_detect(exc_detect), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .pipe_hold(pipe_hold), .flush(flush), .nest_depth(nest_depth),
    .double_fault(double_fault));

  // Second instance held in IDLE by a permanent cancel; only its detect output is exercised.
  exception_tracker #(.XLEN(32), .C_EXT(1), .MISALIGN_TRAP(0), .FLUSH_CYCLES(FC), .MAX_NEST(MN)) u_alt (
    .clk(clk), .reset_n(reset_n), .current_priv(current_priv),
    .if_valid(if_valid), .if_page_fault(if_page_fault), .if_pc(if_pc), .if_fault_vaddr(if_fault_vaddr),
    .id_valid(id_valid), .id_illegal_inst(id_illegal_inst), .id_ecall(id_ecall), .id_ebreak(id_ebreak),
    .id_mret(id_mret), .id_sret(id_sret), .id_pc(id_pc), .id_instruction(id_instruction),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write), .mem_page_fault(mem_page_fault),
    .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_pc(mem_pc), .mem_fault_vaddr(mem_fault_vaddr),
    .exc_cancel(1'b1), .trap_ready(1'b0), .trap_done(1'b0),
    .exc_detect(b_detect), .exc_valid(b_valid), .exc_code(b_code), .exc_pc(b_pc),
    .exc_tval(b_tval), .pipe_hold(b_hold), .flush(b_flush), .nest_depth(b_depth),
    .double_fault(b_df));

  int    n_vec = 0;
  int    n_err = 0;
  exp_t  exp_q[$];
  fexp_t fl_q[$];
  int    m_depth = 0;
  bit    m_df = 0;
  bit    idle_done_en = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t zero_stim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int unsigned pr;
    pr = $urandom_range(0, 2);
    s.priv      = (pr == 2) ? 2'b11 : 2'(pr);
    s.if_valid  = ($urandom_range(0, 2) == 0);
    s.if_pf     = ($urandom_range(0, 3) == 0);
    s.if_pc     = $urandom;
    if ($urandom_range(0, 1) == 1) s.if_pc[1:0] = 2'b00;
    s.if_fva    = $urandom;
    s.id_valid  = ($urandom_range(0, 1) == 1);
    s.ill       = ($urandom_range(0, 5) == 0);
    s.ecall     = ($urandom_range(0, 5) == 0);
    s.ebreak    = ($urandom_range(0, 5) == 0);
    s.mret      = ($urandom_range(0, 5) == 0);
    s.sret      = ($urandom_range(0, 5) == 0);
    s.id_pc     = $urandom;
    s.instr     = $urandom;
    s.mem_valid = ($urandom_range(0, 1) == 1);
    s.rd        = ($urandom_range(0, 1) == 1);
    s.wr        = ($urandom_range(0, 1) == 1);
    s.mpf       = ($urandom_range(0, 3) == 0);
    s.f3        = 3'($urandom_range(0, 7));
    s.maddr     = $urandom;
    if ($urandom_range(0, 1) == 1) s.maddr[2:0] = 3'b000;
    s.mpc       = $urandom;
    s.mfva      = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    current_priv = s.priv;
    if_valid = s.if_valid; if_page_fault = s.if_pf; if_pc = s.if_pc; if_fault_vaddr = s.if_fva;
    id_valid = s.id_valid; id_illegal_inst = s.ill; id_ecall = s.ecall; id_ebreak = s.ebreak;
    id_mret = s.mret; id_sret = s.sret; id_pc = s.id_pc; id_instruction = s.instr;
    mem_valid = s.mem_valid; mem_read = s.rd; mem_write = s.wr; mem_page_fault = s.mpf;
    mem_funct3 = s.f3; mem_addr = s.maddr; mem_pc = s.mpc; mem_fault_vaddr = s.mfva;
  endtask

  // Oldest-first trap rules written as a list of checks; returns 1 when a trap is due.
  function automatic bit model(input stim_t s, input bit mis, input bit cext,
                               output logic [4:0] c, output logic [31:0] p, output logic [31:0] t);
    int unsigned sz;
    bit ld, misal;
    ld = s.rd && !s.wr;
    sz = (s.f3[1:0] == 2'b01) ? 2 : (s.f3[1:0] == 2'b10) ? 4 : 1;
    misal = (s.maddr % sz) != 0;
    c = '0; p = '0; t = '0;
    if (s.mem_valid) begin
      p = s.mpc; t = s.mfva;
      if (s.wr && s.mpf) begin c = 5'd15; return 1; end
      if (ld && s.mpf)   begin c = 5'd13; return 1; end
      t = s.maddr;
      if (mis && misal && ld)   begin c = 5'd4; return 1; end
      if (mis && misal && s.wr) begin c = 5'd6; return 1; end
    end
    if (s.id_valid) begin
      p = s.id_pc;
      if (s.ill || (s.mret && s.priv != 2'd3) || (s.sret && s.priv == 2'd0)) begin
        c = 5'd2; t = s.instr; return 1;
      end
      if (s.ebreak) begin c = 5'd3; t = s.id_pc; return 1; end
      if (s.ecall)  begin c = 5'(8 + s.priv); t = '0; return 1; end
    end
    if (s.if_valid) begin
      p = s.if_pc;
      if ((s.if_pc % (cext ? 2 : 4)) != 0) begin c = 5'd0; t = s.if_pc; return 1; end
      if (s.if_pf) begin c = 5'd12; t = s.if_fva; return 1; end
    end
    c = '0; p = '0; t = '0;
    return 0;
  endfunction

  // Monitor: pops expectations when the DUT presents an exception or starts a flush.
  exp_t  cur;
  fexp_t fcur;
  int    vrun = 0, frun = 0;
  bit    pv = 0, pf = 0;
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      pv = 0; pf = 0; vrun = 0; frun = 0;
    end else begin
      if (exc_valid) begin
        if (!pv) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_exc: got code %0d with empty scoreboard at %0t", exc_code, $time);
          end else begin
            cur = exp_q.pop_front();
            check("exc_code", 96'(exc_code), 96'(cur.code));
            check("exc_pc", 96'(exc_pc), 96'(cur.pc));
            check("exc_tval", 96'(exc_tval), 96'(cur.tval));
          end
          vrun = 1;
        end else begin
          vrun++;
          check("exc_hold", {exc_code, exc_pc, exc_tval}, {cur.code, cur.pc, cur.tval});
        end
      end else if (pv) begin
        check("pending_len", 96'(vrun), 96'(cur.len));
      end
      if (flush) begin
        if (!pf) begin
          if (fl_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_flush: got flush with no handshake at %0t", $time);
          end else begin
            fcur = fl_q.pop_front();
            check("nest_depth", 96'(nest_depth), 96'(fcur.depth));
            check("double_fault", 96'(double_fault), 96'(fcur.df));
          end
          frun = 1;
        end else begin
          frun++;
        end
        check("flush_novalid", 96'(exc_valid), 96'(0));
      end else if (pf) begin
        check("flush_len", 96'(frun), 96'(FC));
      end
      pv = exc_valid;
      pf = flush;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete(); fl_q.delete();
    m_depth = 0; m_df = 0;
    drive(zero_stim());
    exc_cancel = 0; trap_ready = 0; trap_done = 0;
    #1;
    check("reset_outputs", {exc_detect, exc_valid, exc_code, exc_pc, exc_tval, pipe_hold,
                            flush, nest_depth, double_fault}, '0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic txn(input stim_t s, input int plen, input bit cancel, input bit rdy_c,
                     input bit done, input bit idle_cancel);
    logic [4:0] c, cb;
    logic [31:0] p, t, pb, tb;
    bit fa, fb, dn;
    exp_t e;
    fexp_t fe;
    @(negedge clk);
    drive(s);
    exc_cancel = idle_cancel; trap_ready = 0; trap_done = 0;
    fa = model(s, 1'b1, 1'b0, c, p, t);
    fb = model(s, 1'b0, 1'b1, cb, pb, tb);
    #1;
    check("detect", 96'(exc_detect), 96'(fa));
    check("detect_alt", 96'(b_detect), 96'(fb));
    if (fa && !idle_cancel) begin
      e.code = c; e.pc = p; e.tval = t; e.len = plen;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (!(fa && !idle_cancel)) return;
    for (int k = 1; k <= plen; k++) begin
      @(negedge clk);
      drive(rand_stim());
      exc_cancel = 0; trap_ready = 0; trap_done = 0;
      if (k == plen) begin
        if (cancel) begin
          exc_cancel = 1; trap_ready = rdy_c;
        end else begin
          trap_ready = 1; trap_done = done;
          if (m_depth == MN) m_df = 1;
          if (!done && m_depth < MN) m_depth++;
          fe.depth = m_depth; fe.df = m_df;
          fl_q.push_back(fe);
        end
      end
      @(posedge clk);
    end
    if (!cancel) begin
      for (int k = 0; k < FC; k++) begin
        @(negedge clk);
        drive(rand_stim());
        exc_cancel = 1'($urandom_range(0, 1)); trap_ready = 1'($urandom_range(0, 1)); trap_done = 0;
        @(posedge clk);
      end
    end
    @(negedge clk);
    drive(zero_stim());
    exc_cancel = 0; trap_ready = 0;
    dn = idle_done_en && ($urandom_range(0, 2) == 0);
    trap_done = dn;
    if (dn && m_depth > 0) m_depth--;
    @(posedge clk);
    #1;
    check("idle_state", {exc_valid, flush, pipe_hold}, '0);
    check("idle_depth", 96'(nest_depth), 96'(m_depth));
    check("idle_df", 96'(double_fault), 96'(m_df));
    check("alt_quiet", {b_valid, b_hold, b_flush, b_depth, b_df, b_code, b_pc, b_tval}, '0);
  endtask

  initial begin
    stim_t s;
    exp_t e;
    fexp_t fe;
    logic [4:0] c;
    logic [31:0] p, t;
    reset_n = 1'b0;
    drive(zero_stim());
    exc_cancel = 0; trap_ready = 0; trap_done = 0;
    @(negedge clk);
    do_reset();

    s = zero_stim();
    s.if_valid = 1; s.if_pc = 32'h102;
    s.mem_valid = 1; s.rd = 1; s.mpf = 1; s.mfva = 32'h8000_0004; s.mpc = 32'h400;
    txn(s, 1, 0, 0, 0, 0);

    s = zero_stim();
    s.priv = 2'b01; s.id_valid = 1; s.ecall = 1; s.id_pc = 32'h200;
    txn(s, 3, 0, 0, 0, 0);

    s = zero_stim();
    s.priv = 2'b00; s.id_valid = 1; s.mret = 1; s.id_pc = 32'h300; s.instr = 32'h3020_0073;
    txn(s, 2, 0, 0, 0, 0);
    check("df_after_third", 96'(double_fault), 96'(1));

    s = zero_stim();
    s.mem_valid = 1; s.wr = 1; s.f3 = 3'b010; s.maddr = 32'h1002; s.mpc = 32'h500;
    txn(s, 1, 1, 1, 0, 0);
    check("df_sticky", 96'(double_fault), 96'(1));
    txn(s, 1, 0, 0, 0, 1);

    @(negedge clk);
    do_reset();

    s = zero_stim();
    s.priv = 2'b11; s.id_valid = 1; s.ecall = 1; s.id_pc = 32'h600;
    drive(s);
    void'(model(s, 1'b1, 1'b0, c, p, t));
    e.code = c; e.pc = p; e.tval = t; e.len = 1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    drive(zero_stim());
    trap_ready = 1;
    m_depth = 1;
    fe.depth = 1; fe.df = 0;
    fl_q.push_back(fe);
    @(posedge clk);
    @(negedge clk);
    trap_ready = 0;
    #1;
    check("flush_before_reset", 96'(flush), 96'(1));
    do_reset();

    idle_done_en = 1;
    repeat (400) begin
      txn(rand_stim(), int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 96'(exp_q.size()), 96'(0));
    check("flush_q_drained", 96'(fl_q.size()), 96'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
